// File: rtl/tabla_seq_checker.sv
// Sweeps all input rows of a small combinational block and checks its Y
// output against an expected truth table, reporting mismatches per row.
module tabla_seq_checker #(
    parameter int                   N_IN     = 3,
    parameter logic [2**N_IN-1:0]   EXPECTED = 8'b10010110,
    parameter int                   DWELL    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                hold,
    output logic [N_IN-1:0]     vec,
    input  logic                y_in,
    output logic                busy,
    output logic                sample_valid,
    output logic [N_IN-1:0]     sample_index,
    output logic                done,
    output logic                pass,
    output logic [N_IN:0]       err_count,
    output logic [2**N_IN-1:0]  mismatch_mask
);

    localparam int ROWS = 2**N_IN;
    localparam int DW   = $clog2(DWELL) + 1;

    localparam logic [N_IN-1:0] LAST_ROW = N_IN'(ROWS - 1);
    localparam logic [DW-1:0]   LAST_DW  = DW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [N_IN:0]     err_q, err_d;
    logic [ROWS-1:0]   mask_q, mask_d;
    logic              sv_q, sv_d;
    logic [N_IN-1:0]   sidx_q, sidx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            vec_q   <= '0;
            dwell_q <= '0;
            err_q   <= '0;
            mask_q  <= '0;
            sv_q    <= 1'b0;
            sidx_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            dwell_q <= dwell_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            sv_q    <= sv_d;
            sidx_q  <= sidx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        dwell_d = dwell_q;
        err_d   = err_q;
        mask_d  = mask_q;
        sv_d    = 1'b0;
        sidx_d  = sidx_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = APPLY;
                    vec_d   = '0;
                    dwell_d = '0;
                    err_d   = '0;
                    mask_d  = '0;
                end
            end
            APPLY: begin
                if (!hold) begin
                    if (dwell_q != LAST_DW) begin
                        dwell_d = dwell_q + 1'b1;
                    end else begin
                        sv_d   = 1'b1;
                        sidx_d = vec_q;
                        if (y_in != EXPECTED[vec_q]) begin
                            mask_d[vec_q] = 1'b1;
                            err_d         = err_q + 1'b1;
                        end
                        // Last row stays on vec so DONE shows where the sweep ended
                        if (vec_q == LAST_ROW) begin
                            state_d = DONE;
                        end else begin
                            vec_d   = vec_q + 1'b1;
                            dwell_d = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q == APPLY);
        done          = (state_q == DONE);
        pass          = (state_q == DONE) && (err_q == '0);
        vec           = vec_q;
        sample_valid  = sv_q;
        sample_index  = sidx_q;
        err_count     = err_q;
        mismatch_mask = mask_q;
    end

endmodule

// File: tb/tb_tabla_seq_checker.sv
// Directed bench for tabla_seq_checker: default DWELL instance plus a
// DWELL=3 instance, with hand-computed expectations.
module tb_tabla_seq_checker;

    localparam logic [7:0] EXP = 8'b10010110;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic       good_model = 1'b1;
    logic [2:0] vec;
    logic       y_in;
    logic       busy, sv, done, pass;
    logic [2:0] sidx;
    logic [3:0] err;
    logic [7:0] mask;

    logic       start3 = 1'b0;
    logic [2:0] vec3;
    logic       y3;
    logic       busy3, sv3, done3, pass3;
    logic [2:0] sidx3;
    logic [3:0] err3;
    logic [7:0] mask3;

    int total = 0;
    int bad = 0;
    int n;

    always #5 clk = ~clk;

    assign y_in = good_model ? EXP[vec] : 1'b0;
    assign y3   = EXP[vec3];

    tabla_seq_checker u_dut (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .vec(vec), .y_in(y_in), .busy(busy), .sample_valid(sv),
        .sample_index(sidx), .done(done), .pass(pass),
        .err_count(err), .mismatch_mask(mask)
    );

    tabla_seq_checker #(.DWELL(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .hold(1'b0),
        .vec(vec3), .y_in(y3), .busy(busy3), .sample_valid(sv3),
        .sample_index(sidx3), .done(done3), .pass(pass3),
        .err_count(err3), .mismatch_mask(mask3)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vec", vec, 0);
        chk("rst_err", err, 0);
        chk("rst_mask", mask, 0);
        chk("rst_sv", sv, 0);

        // start and reset together: reset wins
        start = 1'b1;
        reset = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        chk("rst_wins", busy, 0);

        // 1: correct model, DWELL=1
        do_start();
        chk("t1_busy", busy, 1);
        chk("t1_vec0", vec, 0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk($sformatf("t1_sv%0d", c), sv, 1);
            chk($sformatf("t1_idx%0d", c), sidx, c - 1);
            chk($sformatf("t1_done%0d", c), done, (c == 8));
        end
        chk("t1_pass", pass, 1);
        chk("t1_err", err, 0);
        chk("t1_mask", mask, 8'h00);
        chk("t1_vec7", vec, 7);
        tick();
        chk("t1_sv_off", sv, 0);
        chk("t1_done_hold", done, 1);

        // 2: y tied low, restart from DONE
        good_model = 1'b0;
        do_start();
        run_to_done(n);
        chk("t2_cyc", n, 8);
        chk("t2_err", err, 4);
        chk("t2_mask", mask, 8'b10010110);
        chk("t2_pass", pass, 0);

        // 6: restart after failure with good model, start ignored mid-sweep
        good_model = 1'b1;
        do_start();
        chk("t6_err_clr", err, 0);
        chk("t6_mask_clr", mask, 0);
        chk("t6_busy", busy, 1);
        tick();
        tick();
        chk("t6_vec2", vec, 2);
        do_start();
        chk("t6_ign", vec, 3);
        run_to_done(n);
        chk("t6_cyc", n, 5);
        chk("t6_pass", pass, 1);

        // 4: hold three cycles at vec=2
        do_start();
        n = 0;
        tick();
        tick();
        n = 2;
        chk("t4_vec2", vec, 2);
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n++;
            chk($sformatf("t4_hvec%0d", c), vec, 2);
            chk($sformatf("t4_hsv%0d", c), sv, 0);
        end
        hold = 1'b0;
        tick();
        n++;
        chk("t4_vec3", vec, 3);
        chk("t4_sidx", sidx, 2);
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("t4_cyc", n, 11);
        chk("t4_pass", pass, 1);

        // 5: reset mid-sweep with errors accumulated
        good_model = 1'b0;
        do_start();
        tick();
        tick();
        tick();
        chk("t5_vec3", vec, 3);
        chk("t5_err2", err, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_vec", vec, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_err", err, 0);
        chk("t5_mask", mask, 0);
        good_model = 1'b1;
        do_start();
        run_to_done(n);
        chk("t5_cyc", n, 8);
        chk("t5_pass", pass, 1);

        // 3: DWELL=3 instance
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("t3_vec0", vec3, 0);
        for (int c = 1; c <= 24; c++) begin
            tick();
            chk($sformatf("t3_vec%0d", c), vec3, (c < 24) ? c / 3 : 7);
            chk($sformatf("t3_sv%0d", c), sv3, (c % 3 == 0));
            chk($sformatf("t3_done%0d", c), done3, (c == 24));
        end
        chk("t3_pass", pass3, 1);
        chk("t3_err", err3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
